// File: rtl/vectorsum_pkg.sv
// Shared types and default sizing for the vectorsum
// engine and the arbiter that schedules jobs onto it.
package vectorsum_pkg;

  localparam int NUM_REQ_DEF        = 4;
  localparam int ID_WIDTH_DEF       = 2;
  localparam int TIMEOUT_CYCLES_DEF = 4096;
  localparam int CNT_WIDTH_DEF      = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_CLR,
    WAIT_DONE,
    ACK,
    FAULT
  } arb_state_t;

endpackage

// File: rtl/vectorsum_arbiter_rr_pick.sv
// Round-robin winner select: first set request at or
// after rr_ptr, wrapping modulo NUM_REQ.
module rr_pick
  import vectorsum_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int ID_WIDTH = ID_WIDTH_DEF
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic                valid,
  output logic [ID_WIDTH-1:0] winner
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;

  function automatic logic [ID_WIDTH-1:0] wrap_id(
    input int v
  );
    return ID_WIDTH'(v >= NUM_REQ ? v - NUM_REQ : v);
  endfunction

  // rot[i] is the request i slots after rr_ptr
  assign dbl = {req, req};
  assign rot = NUM_REQ'(dbl >> rr_ptr);

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid  = 1'b1;
        winner = wrap_id(int'(rr_ptr) + i);
      end
    end
  end

endmodule

// File: rtl/vectorsum_arbiter.sv
// Shares one vectorsum engine among NUM_REQ requesters:
// round-robin grant, start/done handshake, timeout recovery.
module vectorsum_arbiter
  import vectorsum_pkg::*;
#(
  parameter int NUM_REQ        = NUM_REQ_DEF,
  parameter int ID_WIDTH       = ID_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_WIDTH      = CNT_WIDTH_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  output logic [ID_WIDTH-1:0]  sel,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   err,
  output logic                 vs_start,
  input  logic                 vs_done,
  output logic                 vs_clear,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] job_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  arb_state_t           state;
  arb_state_t           state_d;
  logic [NUM_REQ-1:0]   grant_d;
  logic [ID_WIDTH-1:0]  sel_d;
  logic [ID_WIDTH-1:0]  rr_ptr;
  logic [ID_WIDTH-1:0]  rr_ptr_d;
  logic [ID_WIDTH-1:0]  next_ptr;
  logic [ID_WIDTH-1:0]  pick_id;
  logic                 pick_valid;
  logic [TW-1:0]        timer;
  logic [TW-1:0]        timer_d;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 expired;

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  assign expired  = (timer == T_LAST);
  assign busy     = (state != IDLE);
  assign next_ptr =
    (sel == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                     : sel + ID_WIDTH'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      grant     <= '0;
      sel       <= '0;
      rr_ptr    <= '0;
      timer     <= '0;
      job_count <= '0;
    end else begin
      state     <= state_d;
      grant     <= grant_d;
      sel       <= sel_d;
      rr_ptr    <= rr_ptr_d;
      timer     <= timer_d;
      job_count <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state;
    grant_d  = grant;
    sel_d    = sel;
    rr_ptr_d = rr_ptr;
    timer_d  = timer;
    cnt_d    = job_count;
    ack      = '0;
    err      = '0;
    vs_start = 1'b0;
    vs_clear = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_d = NUM_REQ'(1) << pick_id;
          sel_d   = pick_id;
          state_d = START;
        end
      end
      START: begin
        vs_start = 1'b1;
        timer_d  = '0;
        state_d  = WAIT_CLR;
      end
      // done still high here is left over from the last job
      WAIT_CLR: begin
        timer_d = timer + TW'(1);
        if (expired) begin
          state_d = FAULT;
        end else if (!vs_done) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        timer_d = timer + TW'(1);
        if (vs_done) begin
          state_d = ACK;
        end else if (expired) begin
          state_d = FAULT;
        end
      end
      ACK: begin
        ack      = grant;
        grant_d  = '0;
        cnt_d    = job_count + CNT_WIDTH'(1);
        rr_ptr_d = next_ptr;
        state_d  = IDLE;
      end
      FAULT: begin
        err      = grant;
        vs_clear = 1'b1;
        grant_d  = '0;
        rr_ptr_d = next_ptr;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vectorsum_arbiter.sv
// Directed bench for vectorsum_arbiter with a job-level
// reference model and a small vectorsum engine stand-in.
module tb_vectorsum_arbiter;

  localparam int NR      = 4;
  localparam int IW      = 2;
  localparam int TO      = 64;
  localparam int CW      = 16;
  localparam int ENG_CYC = 2 * 8 + 4;

  logic          clock   = 1'b0;
  logic          reset   = 1'b1;
  logic [NR-1:0] req     = '0;
  logic          vs_done = 1'b0;
  logic [NR-1:0] grant;
  logic [IW-1:0] sel;
  logic [NR-1:0] ack;
  logic [NR-1:0] err;
  logic          vs_start;
  logic          vs_clear;
  logic          busy;
  logic [CW-1:0] job_count;

  vectorsum_arbiter #(
    .NUM_REQ        (NR),
    .ID_WIDTH       (IW),
    .TIMEOUT_CYCLES (TO),
    .CNT_WIDTH      (CW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .grant     (grant),
    .sel       (sel),
    .ack       (ack),
    .err       (err),
    .vs_start  (vs_start),
    .vs_done   (vs_done),
    .vs_clear  (vs_clear),
    .busy      (busy),
    .job_count (job_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // engine: done drops after start, rises ENG_CYC later
  bit   hang  = 1'b0;
  int   eng_cnt = 0;
  logic st_s  = 1'b0;
  logic clr_s = 1'b0;

  always @(negedge clock) begin
    st_s  = vs_start;
    clr_s = vs_clear;
  end

  always @(posedge clock) begin
    #1;
    if (clr_s) begin
      vs_done = 1'b0;
      eng_cnt = 0;
    end else if (st_s) begin
      vs_done = 1'b0;
      eng_cnt = ENG_CYC;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0 && !hang) vs_done = 1'b1;
    end
  end

  // job-level reference model
  typedef enum {PH_IDLE, PH_GO, PH_RUN} ph_t;
  ph_t m_ph   = PH_IDLE;
  int  m_owner = 0;
  int  m_sel  = 0;
  int  m_next = 0;
  int  m_jobs = 0;
  int  m_t0   = 0;
  bit  m_low  = 1'b0;
  bit  m_rdy  = 1'b0;
  bit  mon_en = 1'b0;
  int  cyc    = 0;
  int  starts = 0;
  int  acks   = 0;
  int  log_q[$];

  function automatic int rr_model(input logic [NR-1:0] r,
                                  input int from);
    for (int i = 0; i < NR; i++) begin
      if (((int'(r) >> ((from + i) % NR)) & 1) != 0)
        return (from + i) % NR;
    end
    return 0;
  endfunction

  always @(negedge clock) begin
    int eg, ea, ee, es, ec, eb;
    if (mon_en) begin
      cyc++;
      if (vs_start) begin
        starts++;
        log_q.push_back(int'(sel));
      end
      if (ack != 0) acks++;
      if (!reset) begin
        chk("rst_grant", grant, 0);
        chk("rst_sel", sel, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_start", vs_start, 0);
        chk("rst_clear", vs_clear, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", job_count, 0);
        m_ph   = PH_IDLE;
        m_next = 0;
        m_sel  = 0;
        m_jobs = 0;
      end else begin
        eg = 0; ea = 0; ee = 0;
        es = 0; ec = 0; eb = 0;
        case (m_ph)
          PH_GO: begin
            eg = 1 << m_owner;
            es = 1;
            eb = 1;
            m_sel = m_owner;
            m_t0  = cyc;
            m_low = 1'b0;
            m_rdy = 1'b0;
          end
          PH_RUN: begin
            eg = 1 << m_owner;
            eb = 1;
            if (m_rdy) begin
              ea = eg;
            end else if (cyc == m_t0 + TO + 1) begin
              ee = eg;
              ec = 1;
            end
          end
          default: ;
        endcase
        chk("grant", grant, eg);
        chk("sel", sel, m_sel);
        chk("ack", ack, ea);
        chk("err", err, ee);
        chk("vs_start", vs_start, es);
        chk("vs_clear", vs_clear, ec);
        chk("busy", busy, eb);
        chk("job_count", job_count, m_jobs & 16'hffff);
        case (m_ph)
          PH_IDLE: begin
            if (req != 0) begin
              m_owner = rr_model(req, m_next);
              m_ph    = PH_GO;
            end
          end
          PH_GO: m_ph = PH_RUN;
          PH_RUN: begin
            if (ea != 0 || ee != 0) begin
              if (ea != 0) m_jobs++;
              m_next = (m_owner + 1) % NR;
              m_ph   = PH_IDLE;
            end else if (!m_low) begin
              if (!vs_done) m_low = 1'b1;
            end else if (vs_done) begin
              m_rdy = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_end(input logic [NR-1:0] e_ack,
                          input logic [NR-1:0] e_err,
                          input string nm);
    int k;
    k = 0;
    @(negedge clock);
    while ((ack | err) == 0 && k < 300) begin
      @(negedge clock);
      k++;
    end
    if ((ack | err) == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_end got=none exp=ack/err", nm);
    end else begin
      chk({nm, "_ack"}, ack, e_ack);
      chk({nm, "_err"}, err, e_err);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0, s0, k;
    int exp_order[5];
    logic [NR-1:0] e;
    exp_order = '{0, 1, 2, 3, 0};
    #2 reset = 1'b0;
    #1 mon_en = 1'b1;
    tick(3);
    @(negedge clock);
    chk("init_busy", busy, 0);
    chk("init_count", job_count, 0);
    tick(1);
    reset = 1'b1;
    tick(2);

    // single request from idle
    req = 4'b0100;
    @(negedge clock);
    @(negedge clock);
    chk("t1_grant", grant, 4'b0100);
    chk("t1_sel", sel, 2);
    chk("t1_start", vs_start, 1);
    wait_end(4'b0100, 4'b0000, "t1");
    tick(1);
    req = '0;
    @(negedge clock);
    chk("t1_count", job_count, 1);

    // wrap 3 -> 0
    tick(1);
    req = 4'b1000;
    wait_end(4'b1000, 4'b0000, "t3a");
    tick(1);
    req = 4'b1001;
    @(negedge clock);
    @(negedge clock);
    chk("t3_grant", grant, 4'b0001);
    wait_end(4'b0001, 4'b0000, "t3b");
    tick(1);
    req = 4'b1000;
    wait_end(4'b1000, 4'b0000, "t3c");

    // all requesting, pointer at 0
    tick(1);
    req = 4'b1111;
    log_q.delete();
    a0 = acks;
    for (int j = 0; j < 5; j++) begin
      e = 4'b0001 << (j % 4);
      wait_end(e, 4'b0000, "t2");
    end
    tick(1);
    req = '0;
    tick(2);
    @(negedge clock);
    chk("t2_jobs", log_q.size(), 5);
    for (int j = 0; j < 5 && j < log_q.size(); j++)
      chk("t2_order", log_q[j], exp_order[j]);
    chk("t2_acks", acks - a0, 5);
    chk("t2_count", job_count, 9);

    // request dropped mid-job
    tick(1);
    s0 = starts;
    req = 4'b0010;
    repeat (6) @(negedge clock);
    chk("t5_busy", busy, 1);
    tick(1);
    req = '0;
    wait_end(4'b0010, 4'b0000, "t5");
    tick(2);
    @(negedge clock);
    chk("t5_starts", starts - s0, 1);
    chk("t5_count", job_count, 10);

    // hung engine
    tick(1);
    hang = 1'b1;
    req = 4'b0101;
    k = 0;
    while (!vs_start && k < 10) begin
      @(negedge clock);
      k++;
    end
    chk("t4_start", vs_start, 1);
    k = 0;
    while ((ack | err) == 0 && k < 200) begin
      @(negedge clock);
      k++;
    end
    chk("t4_latency", k, 65);
    chk("t4_err", err, 4'b0100);
    chk("t4_ack", ack, 4'b0000);
    chk("t4_clear", vs_clear, 1);
    chk("t4_count", job_count, 10);
    tick(1);
    hang = 1'b0;
    req = 4'b0001;
    @(negedge clock);
    @(negedge clock);
    chk("t4_next", grant, 4'b0001);
    wait_end(4'b0001, 4'b0000, "t4b");
    tick(1);
    req = '0;

    // reset mid-job
    tick(1);
    req = 4'b0010;
    @(negedge clock);
    @(negedge clock);
    chk("t6_grant", grant, 4'b0010);
    repeat (5) @(negedge clock);
    tick(1);
    reset = 1'b0;
    req = '0;
    #1;
    chk("t6_grant0", grant, 0);
    chk("t6_busy0", busy, 0);
    chk("t6_ack0", ack, 0);
    chk("t6_err0", err, 0);
    chk("t6_count0", job_count, 0);
    tick(2);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    chk("t6_idle", busy, 0);
    chk("t6_nogrant", grant, 0);
    tick(1);
    req = 4'b0011;
    @(negedge clock);
    @(negedge clock);
    chk("t6_regrant", grant, 4'b0001);
    wait_end(4'b0001, 4'b0000, "t6");
    tick(1);
    req = '0;
    @(negedge clock);
    chk("t6_count", job_count, 1);

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
